vortex_afu_ctrl_regs: RTL and testbench

Parametrised AXI4-Lite control/status slave for the XRT AFU top. It decodes host register accesses into the ap_ctrl_hs kernel handshake (start/done/idle/ready), per-source interrupt enable/status and a configurable bank of 64-bit kernel argument registers. It sits between s_axi_ctrl and the Vortex core launch logic and replaces the fixed-layout control decode with one generalised in argument count, interrupt sources and auto-restart mode.

---
 rtl/vortex_afu_pkg.sv | 26 ++
 rtl/vortex_afu_arg_regs.sv | 47 ++++
 rtl/vortex_afu_ctrl_regs.sv | 195 +++++++++++++++++++
 tb/tb_vortex_afu_ctrl_regs.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vortex_afu_pkg.sv
// rtl/vortex_afu_pkg.sv - shared register map, bit indices and channel FSM states
package vortex_afu_pkg;

  localparam int unsigned CTRL_OFF = 'h00;
  localparam int unsigned GIE_OFF  = 'h04;
  localparam int unsigned IER_OFF  = 'h08;
  localparam int unsigned ISR_OFF  = 'h0C;
  localparam int unsigned ARG_BASE = 'h10;

  localparam int CTRL_START        = 0;
  localparam int CTRL_DONE         = 1;
  localparam int CTRL_IDLE         = 2;
  localparam int CTRL_READY        = 3;
  localparam int CTRL_AUTO_RESTART = 7;

  localparam int ISR_DONE  = 0;
  localparam int ISR_READY = 1;

  typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_ADDR, R_DATA} r_state_t;

  typedef enum logic [2:0] {
    SEL_NONE, SEL_CTRL, SEL_GIE, SEL_IER, SEL_ISR, SEL_ARG
  } reg_sel_t;

endpackage

// File: rtl/vortex_afu_arg_regs.sv
// rtl/vortex_afu_arg_regs.sv - bank of byte-strobed 64-bit kernel argument registers
module vortex_afu_arg_regs #(
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_ARGS   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_off,
  input  logic [31:0]             wdata,
  input  logic [3:0]              wstrb,
  input  logic [ADDR_WIDTH-1:0]   rd_off,
  output logic [31:0]             rd_data,
  output logic [64*NUM_ARGS-1:0]  args
);

  localparam int NUM_WORDS = 2 * NUM_ARGS;

  // Word w sits at byte offset 4*w from the bank base; even words are the low halves.
  logic [31:0] words [NUM_WORDS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WORDS; w++) words[w] <= '0;
    end else if (wr_en) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        if (wr_off == ADDR_WIDTH'(4 * w)) begin
          for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) words[w][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      if (rd_off == ADDR_WIDTH'(4 * w)) rd_data = words[w];
    end
  end

  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_args
    assign args[32*w +: 32] = words[w];
  end

endmodule

// File: rtl/vortex_afu_ctrl_regs.sv
// rtl/vortex_afu_ctrl_regs.sv - AXI4-Lite control slave: ap_ctrl_hs handshake, interrupts, argument bank
module vortex_afu_ctrl_regs
  import vortex_afu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ARGS   = 2
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    s_axi_ctrl_awvalid,
  output logic                    s_axi_ctrl_awready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_ctrl_awaddr,
  input  logic                    s_axi_ctrl_wvalid,
  output logic                    s_axi_ctrl_wready,
  input  logic [DATA_WIDTH-1:0]   s_axi_ctrl_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_ctrl_wstrb,
  output logic                    s_axi_ctrl_bvalid,
  input  logic                    s_axi_ctrl_bready,
  output logic [1:0]              s_axi_ctrl_bresp,
  input  logic                    s_axi_ctrl_arvalid,
  output logic                    s_axi_ctrl_arready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_ctrl_araddr,
  output logic                    s_axi_ctrl_rvalid,
  input  logic                    s_axi_ctrl_rready,
  output logic [DATA_WIDTH-1:0]   s_axi_ctrl_rdata,
  output logic [1:0]              s_axi_ctrl_rresp,
  output logic                    ap_start,
  input  logic                    ap_ready,
  input  logic                    ap_done,
  input  logic                    ap_idle,
  output logic [64*NUM_ARGS-1:0]  args,
  output logic                    interrupt
);

  // Misaligned addresses never hit a register.
  function automatic reg_sel_t decode(input logic [ADDR_WIDTH-1:0] a);
    reg_sel_t sel;
    sel = SEL_NONE;
    if (a[1:0] == 2'b00) begin
      if (a == ADDR_WIDTH'(CTRL_OFF))     sel = SEL_CTRL;
      else if (a == ADDR_WIDTH'(GIE_OFF)) sel = SEL_GIE;
      else if (a == ADDR_WIDTH'(IER_OFF)) sel = SEL_IER;
      else if (a == ADDR_WIDTH'(ISR_OFF)) sel = SEL_ISR;
      else if (a >= ADDR_WIDTH'(ARG_BASE) &&
               (a - ADDR_WIDTH'(ARG_BASE)) < ADDR_WIDTH'(8 * NUM_ARGS))
        sel = SEL_ARG;
    end
    return sel;
  endfunction

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] rdata_q, rd_word, arg_rd_data;
  logic                  ap_start_q, auto_restart_q, done_q, ready_q, gie_q, interrupt_q;
  logic [1:0]            ier_q, isr_q, isr_event;
  logic                  aw_fire, w_fire, ar_fire, byte0_wr, rd_ctrl_clr;
  reg_sel_t              wr_sel, rd_sel;

  assign wr_sel      = decode(aw_addr_q);
  assign rd_sel      = decode(s_axi_ctrl_araddr);
  assign byte0_wr    = w_fire && s_axi_ctrl_wstrb[0];
  assign rd_ctrl_clr = ar_fire && (rd_sel == SEL_CTRL);

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      w_state   <= W_ADDR;
      r_state   <= R_ADDR;
      aw_addr_q <= '0;
      rdata_q   <= '0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      if (aw_fire) aw_addr_q <= s_axi_ctrl_awaddr;
      if (ar_fire) rdata_q   <= rd_word;
    end
  end

  always_comb begin
    w_next             = w_state;
    s_axi_ctrl_awready = 1'b0;
    s_axi_ctrl_wready  = 1'b0;
    s_axi_ctrl_bvalid  = 1'b0;
    aw_fire            = 1'b0;
    w_fire             = 1'b0;
    unique case (w_state)
      W_ADDR: begin
        s_axi_ctrl_awready = 1'b1;
        aw_fire            = s_axi_ctrl_awvalid;
        if (s_axi_ctrl_awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        s_axi_ctrl_wready = 1'b1;
        w_fire            = s_axi_ctrl_wvalid;
        if (s_axi_ctrl_wvalid) w_next = W_RESP;
      end
      W_RESP: begin
        s_axi_ctrl_bvalid = 1'b1;
        if (s_axi_ctrl_bready) w_next = W_ADDR;
      end
      default: w_next = W_ADDR;
    endcase
  end

  always_comb begin
    r_next             = r_state;
    s_axi_ctrl_arready = 1'b0;
    s_axi_ctrl_rvalid  = 1'b0;
    ar_fire            = 1'b0;
    unique case (r_state)
      R_ADDR: begin
        s_axi_ctrl_arready = 1'b1;
        ar_fire            = s_axi_ctrl_arvalid;
        if (s_axi_ctrl_arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        s_axi_ctrl_rvalid = 1'b1;
        if (s_axi_ctrl_rready) r_next = R_ADDR;
      end
      default: r_next = R_ADDR;
    endcase
  end

  always_comb begin
    rd_word = '0;
    unique case (rd_sel)
      SEL_CTRL: begin
        rd_word[CTRL_START]        = ap_start_q;
        rd_word[CTRL_DONE]         = done_q;
        rd_word[CTRL_IDLE]         = ap_idle;
        rd_word[CTRL_READY]        = ready_q;
        rd_word[CTRL_AUTO_RESTART] = auto_restart_q;
      end
      SEL_GIE:  rd_word[0]   = gie_q;
      SEL_IER:  rd_word[1:0] = ier_q;
      SEL_ISR:  rd_word[1:0] = isr_q;
      SEL_ARG:  rd_word      = arg_rd_data;
      default:  rd_word      = '0;
    endcase
  end

  assign isr_event[ISR_DONE]  = ap_done;
  assign isr_event[ISR_READY] = ap_ready;

  // Sticky status: a new event in the same cycle as a clearing read or toggle wins.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      ap_start_q     <= 1'b0;
      auto_restart_q <= 1'b0;
      done_q         <= 1'b0;
      ready_q        <= 1'b0;
      gie_q          <= 1'b0;
      ier_q          <= '0;
      isr_q          <= '0;
      interrupt_q    <= 1'b0;
    end else begin
      if (byte0_wr && wr_sel == SEL_CTRL) auto_restart_q <= s_axi_ctrl_wdata[CTRL_AUTO_RESTART];
      if (byte0_wr && wr_sel == SEL_CTRL && s_axi_ctrl_wdata[CTRL_START]) ap_start_q <= 1'b1;
      else if (ap_ready && !auto_restart_q) ap_start_q <= 1'b0;
      done_q  <= ap_done  | (done_q  & ~rd_ctrl_clr);
      ready_q <= ap_ready | (ready_q & ~rd_ctrl_clr);
      if (byte0_wr && wr_sel == SEL_GIE) gie_q <= s_axi_ctrl_wdata[0];
      if (byte0_wr && wr_sel == SEL_IER) ier_q <= s_axi_ctrl_wdata[1:0];
      for (int k = 0; k < 2; k++) begin
        isr_q[k] <= (isr_event[k] & ier_q[k]) |
                    (isr_q[k] ^ (byte0_wr && wr_sel == SEL_ISR && s_axi_ctrl_wdata[k]));
      end
      interrupt_q <= gie_q & (|isr_q);
    end
  end

  vortex_afu_arg_regs #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_ARGS   (NUM_ARGS)
  ) u_arg_regs (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .wr_en   (w_fire && wr_sel == SEL_ARG),
    .wr_off  (aw_addr_q - ADDR_WIDTH'(ARG_BASE)),
    .wdata   (s_axi_ctrl_wdata),
    .wstrb   (s_axi_ctrl_wstrb),
    .rd_off  (s_axi_ctrl_araddr - ADDR_WIDTH'(ARG_BASE)),
    .rd_data (arg_rd_data),
    .args    (args)
  );

  assign s_axi_ctrl_bresp = 2'b00;
  assign s_axi_ctrl_rresp = 2'b00;
  assign s_axi_ctrl_rdata = rdata_q;
  assign ap_start         = ap_start_q;
  assign interrupt        = interrupt_q;

endmodule

// File: tb/tb_vortex_afu_ctrl_regs.sv
// tb/tb_vortex_afu_ctrl_regs.sv - scoreboard bench for vortex_afu_ctrl_regs
module tb_vortex_afu_ctrl_regs;

  localparam int AW = 8;
  localparam int NA = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ap_rst_n;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic ap_start, ap_ready, ap_done, ap_idle, interrupt;
  logic [64*NA-1:0] args;

  vortex_afu_ctrl_regs #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .NUM_ARGS(NA)) dut (
    .ap_clk(clk), .ap_rst_n(ap_rst_n),
    .s_axi_ctrl_awvalid(awvalid), .s_axi_ctrl_awready(awready), .s_axi_ctrl_awaddr(awaddr),
    .s_axi_ctrl_wvalid(wvalid), .s_axi_ctrl_wready(wready), .s_axi_ctrl_wdata(wdata),
    .s_axi_ctrl_wstrb(wstrb),
    .s_axi_ctrl_bvalid(bvalid), .s_axi_ctrl_bready(bready), .s_axi_ctrl_bresp(bresp),
    .s_axi_ctrl_arvalid(arvalid), .s_axi_ctrl_arready(arready), .s_axi_ctrl_araddr(araddr),
    .s_axi_ctrl_rvalid(rvalid), .s_axi_ctrl_rready(rready), .s_axi_ctrl_rdata(rdata),
    .s_axi_ctrl_rresp(rresp),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
    .args(args), .interrupt(interrupt)
  );

  // Reference model: host-visible state as plain variables, arguments as a flat byte array.
  logic [7:0] arg_bytes [8*NA];
  bit start_m, auto_m, done_m, ready_m, gie_m, idle_m;
  bit [1:0] ier_m, isr_m;

  logic [31:0] r_q [$];
  logic [1:0]  b_q [$];
  int passed = 0;
  int total = 0;
  bit hold_bp = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8*NA; i++) arg_bytes[i] = 8'h00;
    start_m = 0; auto_m = 0; done_m = 0; ready_m = 0; gie_m = 0; ier_m = 0; isr_m = 0;
  endfunction

  function automatic bit is_arg(input logic [7:0] a);
    return (a[1:0] == 2'b00) && (int'(a) >= 16) && (int'(a) < 16 + 8*NA);
  endfunction

  function automatic logic [64*NA-1:0] model_args();
    logic [64*NA-1:0] v;
    for (int i = 0; i < 8*NA; i++) v[8*i +: 8] = arg_bytes[i];
    return v;
  endfunction

  function automatic void model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    if (is_arg(a)) begin
      for (int b = 0; b < 4; b++) if (s[b]) arg_bytes[int'(a) - 16 + b] = d[8*b +: 8];
    end else if (s[0]) begin
      case (a)
        8'h00: begin auto_m = d[7]; if (d[0]) start_m = 1; end
        8'h04: gie_m = d[0];
        8'h08: ier_m = d[1:0];
        8'h0C: isr_m = isr_m ^ d[1:0];
        default: ;
      endcase
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    logic [31:0] v;
    v = 32'h0;
    if (is_arg(a)) begin
      for (int b = 0; b < 4; b++) v[8*b +: 8] = arg_bytes[int'(a) - 16 + b];
    end else begin
      case (a)
        8'h00: begin
          v = {24'h0, auto_m, 3'b000, ready_m, idle_m, done_m, start_m};
          done_m = 0; ready_m = 0;
        end
        8'h04: v = {31'h0, gie_m};
        8'h08: v = {30'h0, ier_m};
        8'h0C: v = {30'h0, isr_m};
        default: v = 32'h0;
      endcase
    end
    return v;
  endfunction

  function automatic void model_pulse(input bit rdy, input bit dn);
    if (dn) begin done_m = 1; if (ier_m[0]) isr_m[0] = 1; end
    if (rdy) begin ready_m = 1; if (ier_m[1]) isr_m[1] = 1; if (!auto_m) start_m = 0; end
  endfunction

  // Random host backpressure on the response channels.
  initial begin
    rready = 1'b0; bready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rready = hold_bp ? 1'b0 : ($urandom_range(0, 3) != 0);
      bready = hold_bp ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard whenever a response handshake is about to complete.
  initial begin
    logic [31:0] er;
    logic [1:0]  eb;
    forever begin
      @(negedge clk);
      if (rvalid && rready) begin
        if (r_q.size() == 0) begin total++; $display("FAIL r_unexpected: got 0x%0h expected none", rdata); end
        else begin
          er = r_q.pop_front();
          check("rdata", 256'(rdata), 256'(er));
          check("rresp", 256'(rresp), 256'(2'b00));
        end
      end
      if (bvalid && bready) begin
        if (b_q.size() == 0) begin total++; $display("FAIL b_unexpected: got 0x%0h expected none", bresp); end
        else begin eb = b_q.pop_front(); check("bresp", 256'(bresp), 256'(eb)); end
      end
    end
  end

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit with_done = 0, input bit wait_b = 1);
    int n;
    @(posedge clk); #1; awvalid = 1; awaddr = a;
    n = 0; do begin @(negedge clk); n++; end while (!awready && n < 50);
    check("awready", 256'(awready), 256'(1));
    @(posedge clk); #1; awvalid = 0; wvalid = 1; wdata = d; wstrb = s;
    if (with_done) ap_done = 1;
    n = 0; do begin @(negedge clk); n++; end while (!wready && n < 50);
    check("wready", 256'(wready), 256'(1));
    b_q.push_back(2'b00);
    model_write(a, d, s);
    if (with_done) model_pulse(0, 1);
    @(posedge clk); #1; wvalid = 0; ap_done = 0;
    if (wait_b) begin
      n = 0; while (b_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
      check("b_timeout", 256'(b_q.size()), 256'(0));
    end
  endtask

  task automatic axi_read(input logic [7:0] a, input bit with_done = 0);
    int n;
    @(posedge clk); #1; arvalid = 1; araddr = a;
    if (with_done) ap_done = 1;
    n = 0; do begin @(negedge clk); n++; end while (!arready && n < 50);
    check("arready", 256'(arready), 256'(1));
    r_q.push_back(model_read(a));
    if (with_done) model_pulse(0, 1);
    @(posedge clk); #1; arvalid = 0; ap_done = 0;
    n = 0; while (r_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check("r_timeout", 256'(r_q.size()), 256'(0));
  endtask

  task automatic pulse(input bit rdy, input bit dn);
    @(posedge clk); #1; ap_ready = rdy; ap_done = dn;
    @(negedge clk);
    check("start_during_pulse", 256'(ap_start), 256'(start_m));
    model_pulse(rdy, dn);
    @(posedge clk); #1; ap_ready = 0; ap_done = 0;
  endtask

  task automatic check_outputs(input string tag);
    @(posedge clk); @(negedge clk);
    check({tag, "_start"}, 256'(ap_start), 256'(start_m));
    check({tag, "_args"}, 256'(args), 256'(model_args()));
    check({tag, "_irq"}, 256'(interrupt), 256'(gie_m & (|isr_m)));
  endtask

  logic [7:0] addr_pool [14] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                                 8'h20, 8'h24, 8'h28, 8'h2A, 8'h30, 8'hFC};

  initial begin
    ap_rst_n = 0; awvalid = 0; awaddr = '0; wvalid = 0; wdata = '0; wstrb = '0;
    arvalid = 0; araddr = '0; ap_ready = 0; ap_done = 0; ap_idle = 1; idle_m = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 ap_rst_n = 1;
    @(negedge clk);
    check("rst_awready", 256'(awready), 256'(1));
    check("rst_arready", 256'(arready), 256'(1));
    check("rst_wready", 256'(wready), 256'(0));
    check("rst_bvalid", 256'(bvalid), 256'(0));
    check("rst_rvalid", 256'(rvalid), 256'(0));
    check("rst_rdata", 256'(rdata), 256'(0));
    check("rst_start", 256'(ap_start), 256'(0));
    check("rst_irq", 256'(interrupt), 256'(0));
    check("rst_args", 256'(args), 256'(0));

    axi_write(8'h10, 32'hDEADBEEF, 4'hF);
    axi_write(8'h14, 32'h12345678, 4'hF);
    check_outputs("arg0");
    check("arg0_value", 256'(args[63:0]), 256'(64'h12345678DEADBEEF));
    axi_read(8'h10);
    axi_read(8'h14);

    axi_write(8'h00, 32'h1, 4'h1);
    check_outputs("start_set");
    pulse(1, 0);
    check_outputs("start_clr");
    axi_read(8'h00);
    axi_read(8'h00);

    axi_write(8'h00, 32'h81, 4'h1);
    pulse(1, 0);
    pulse(1, 0);
    check_outputs("auto_hold");
    axi_write(8'h00, 32'h00, 4'h1);
    pulse(1, 0);
    check_outputs("auto_off");

    axi_write(8'h04, 32'h1, 4'hF);
    axi_write(8'h08, 32'h1, 4'hF);
    pulse(0, 1);
    @(negedge clk); check("irq_delay", 256'(interrupt), 256'(0));
    @(negedge clk); check("irq_set", 256'(interrupt), 256'(1));
    axi_read(8'h0C);
    axi_write(8'h0C, 32'h1, 4'h1);
    check_outputs("isr_clr");

    axi_read(8'h00);
    axi_read(8'h00, 1);
    axi_read(8'h00);
    axi_write(8'h0C, 32'h1, 4'h1, 1);
    axi_read(8'h0C);
    check_outputs("isr_race");

    axi_write(8'h18, 32'h0000AB00, 4'h2);
    check_outputs("partial");
    axi_read(8'h18);
    axi_read(8'hFC);

    for (int i = 0; i < 60; i++) begin
      logic [7:0] a;
      a = addr_pool[$urandom_range(0, 13)];
      case ($urandom_range(0, 4))
        0, 1: axi_write(a, $urandom, 4'($urandom_range(0, 15)));
        2:    axi_read(a);
        3:    pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        default: begin @(posedge clk); #1; ap_idle = 1'($urandom_range(0, 1)); idle_m = ap_idle; end
      endcase
      check_outputs("rand");
    end

    axi_write(8'h00, 32'h1, 4'h1);
    hold_bp = 1;
    @(posedge clk);
    axi_write(8'h10, 32'hCAFEF00D, 4'hF, 0, 0);
    @(negedge clk);
    check("resp_pending", 256'(bvalid), 256'(1));
    @(posedge clk); #1; ap_rst_n = 0;
    @(posedge clk); #1; ap_rst_n = 1;
    b_q.delete();
    model_reset();
    @(negedge clk);
    check("midrst_bvalid", 256'(bvalid), 256'(0));
    check("midrst_awready", 256'(awready), 256'(1));
    check("midrst_start", 256'(ap_start), 256'(0));
    hold_bp = 0;
    check_outputs("post_rst");
    axi_write(8'h24, 32'h600DF00D, 4'hF);
    axi_read(8'h24);
    check_outputs("final");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
